// File: rtl/spi_responder.sv
// SPI mode-0 target exposing 16 byte-wide local registers through write strobes and read fetches.
// Optional interrupt output (nIRQ/IRQ_ACK) is enabled by defining SPI_RESPONDER_IRQ_EN.
module spi_responder #(
  parameter logic [7:0] ID_BYTE     = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       MHZ48,
  input  logic       nRES,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       nCS,
  output logic       MISO,
  output logic       MISO_OE,
  output logic       WSTB,
  output logic [3:0] WADDR,
  output logic [7:0] WDATA,
  output logic [3:0] RADDR,
`ifdef SPI_RESPONDER_IRQ_EN
  input  logic       IRQ_ACK,
  output logic       nIRQ,
`endif
  input  logic [7:0] RDATA
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    CMD,
    DATA
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  logic                   sclk_s, mosi_s, ncs_s;
  logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic                   active, byte_done;

  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] rx_byte;
  logic [7:0] tx_q;
  logic [3:0] addr_q, waddr_q, raddr_q;
  logic [7:0] wdata_q;
  logic       rd_mode_q, fetch_q, wstb_q;

  // NOTE: nCS synchroniser resets to 0 so WAIT_IDLE only leaves once a real high has propagated.
  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
      sclk_dly_q  <= sclk_s;
      ncs_dly_q   <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  assign active    = (state_q == CMD) || (state_q == DATA);
  assign rx_byte   = {rx_q, mosi_s};
  // Deselect takes priority over a byte completing in the same cycle.
  assign byte_done = active && sclk_rise && !ncs_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_IDLE: if (ncs_s) state_d = IDLE;
      IDLE:      if (ncs_fall) state_d = CMD;
      CMD: begin
        if (ncs_rise)       state_d = IDLE;
        else if (byte_done) state_d = DATA;
      end
      DATA:      if (ncs_rise) state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    MISO    = 1'b1;
    MISO_OE = 1'b0;
    if (state_q != WAIT_IDLE) MISO_OE = ~ncs_s;
    if (active)               MISO    = tx_q[7];
  end

  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      rd_mode_q <= 1'b0;
      fetch_q   <= 1'b0;
      wstb_q    <= 1'b0;
    end else begin
      wstb_q  <= 1'b0;
      fetch_q <= 1'b0;
      if (state_q == IDLE && ncs_fall) begin
        bit_cnt_q <= 3'd0;
        rx_q      <= '0;
        tx_q      <= ID_BYTE;
      end else if (active && !ncs_rise) begin
        // The fall right after a byte boundary must not shift, or the freshly loaded MSB is lost.
        if (fetch_q) begin
          tx_q <= RDATA;
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
          tx_q <= {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              rd_mode_q <= rx_byte[7];
              addr_q    <= rx_byte[3:0];
              raddr_q   <= rx_byte[3:0];
              fetch_q   <= rx_byte[7];
            end else if (rd_mode_q) begin
              addr_q  <= addr_q + 4'd1;
              raddr_q <= addr_q + 4'd1;
              fetch_q <= 1'b1;
            end else begin
              waddr_q <= addr_q;
              wdata_q <= rx_byte;
              wstb_q  <= 1'b1;
              addr_q  <= addr_q + 4'd1;
            end
          end
        end
      end
    end
  end

  assign WSTB  = wstb_q;
  assign WADDR = waddr_q;
  assign WDATA = wdata_q;
  assign RADDR = raddr_q;

`ifdef SPI_RESPONDER_IRQ_EN
  logic wr_seen_q, nirq_q, irq_set;

  // Raised only by a write frame that completed at least one data byte.
  assign irq_set = active && ncs_rise && wr_seen_q;

  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      wr_seen_q <= 1'b0;
      nirq_q    <= 1'b1;
    end else begin
      if (state_q == IDLE && ncs_fall) begin
        wr_seen_q <= 1'b0;
      end else if (state_q == DATA && byte_done && !rd_mode_q) begin
        wr_seen_q <= 1'b1;
      end
      if (irq_set) begin
        nirq_q <= 1'b0;
      end else if (IRQ_ACK) begin
        nirq_q <= 1'b1;
      end
    end
  end

  assign nIRQ = nirq_q;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: bit-banged SPI master, strobe monitor and a fixed RDATA model.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       nRES, SCLK, MOSI, nCS;
  logic       MISO, MISO_OE, WSTB;
  logic [3:0] WADDR, RADDR;
  logic [7:0] WDATA, RDATA;
`ifdef SPI_RESPONDER_IRQ_EN
  logic       IRQ_ACK, nIRQ;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  assign RDATA = {4'h5, RADDR};

  spi_responder dut (
    .MHZ48   (clk),
    .nRES    (nRES),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .nCS     (nCS),
    .MISO    (MISO),
    .MISO_OE (MISO_OE),
    .WSTB    (WSTB),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .RADDR   (RADDR),
`ifdef SPI_RESPONDER_IRQ_EN
    .IRQ_ACK (IRQ_ACK),
    .nIRQ    (nIRQ),
`endif
    .RDATA   (RDATA)
  );

  // Strobe monitor: records every strobe cycle and counts strobes wider than one cycle.
  logic [11:0] stb_log[$];
  int          wide_cnt = 0;
  logic        wstb_prev = 1'b0;

  always @(negedge clk) begin
    if (WSTB === 1'b1) stb_log.push_back({WADDR, WDATA});
    if (WSTB === 1'b1 && wstb_prev === 1'b1) wide_cnt++;
    wstb_prev = WSTB;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts nbits of data MSB-first; MISO is sampled just before each SCLK rise.
  task automatic xfer(input logic [7:0] data, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = data[7-i];
      wait_clk(6);
      rx[7-i] = MISO;
      SCLK = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
    end
  endtask

  task automatic select();
    nCS = 1'b0;
    wait_clk(8);
  endtask

  task automatic deselect();
    wait_clk(6);
    nCS = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_strobes(input string tag, input int n, input logic [11:0] exp [3]);
    check({tag, "_count"}, stb_log.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_entry"}, (i < stb_log.size()) ? {20'h0, stb_log[i]} : 32'hFFFF_FFFF,
            {20'h0, exp[i]});
    end
    check({tag, "_width"}, wide_cnt, 0);
    stb_log.delete();
    wide_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    logic [11:0] none [3];
    none = '{12'h000, 12'h000, 12'h000};

    nRES = 1'b0; nCS = 1'b0; SCLK = 1'b0; MOSI = 1'b0;
`ifdef SPI_RESPONDER_IRQ_EN
    IRQ_ACK = 1'b0;
`endif
    wait_clk(5);
    check("rst_miso",  MISO,    1'b1);
    check("rst_oe",    MISO_OE, 1'b0);
    check("rst_wstb",  WSTB,    1'b0);
    check("rst_waddr", WADDR,   4'h0);
    check("rst_wdata", WDATA,   8'h00);
    check("rst_raddr", RADDR,   4'h0);
`ifdef SPI_RESPONDER_IRQ_EN
    check("rst_nirq",  nIRQ,    1'b1);
`endif

    // 1: nCS held low through reset exit is ignored until it has been high.
    nRES = 1'b1;
    wait_clk(5);
    xfer(8'h03, 8, rx);
    xfer(8'h44, 8, rx);
    check("t1_oe_held",   MISO_OE, 1'b0);
    check("t1_miso_held", MISO,    1'b1);
    check("t1_nostb",     stb_log.size(), 0);
    nCS = 1'b1;
    wait_clk(8);
    check("t1_oe_idle", MISO_OE, 1'b0);
    select();
    check("t1_oe_sel", MISO_OE, 1'b1);

    // 2: write frame at address 3 carrying the ID byte check.
    xfer(8'h03, 8, rx);
    check("t1_id", rx, 8'hA5);
    xfer(8'h11, 8, rx);
    xfer(8'h22, 8, rx);
    deselect();
    check_strobes("t2", 2, '{12'h311, 12'h422, 12'h000});

    // 3: address wraps 15 -> 0.
    select();
    xfer(8'h0F, 8, rx);
    xfer(8'hAA, 8, rx);
    xfer(8'hBB, 8, rx);
    xfer(8'hCC, 8, rx);
    deselect();
    check_strobes("t3", 3, '{12'hFAA, 12'h0BB, 12'h1CC});

    // 4: read frame from 14 returns {5, addr} and wraps RADDR to 0.
    select();
    xfer(8'h8E, 8, rx);
    check("t4_id",     rx,    8'hA5);
    check("t4_raddr0", RADDR, 4'hE);
    xfer(8'h00, 8, rx);
    check("t4_rd0",    rx,    8'h5E);
    check("t4_raddr1", RADDR, 4'hF);
    xfer(8'hFF, 8, rx);
    check("t4_rd1",    rx,    8'h5F);
    check("t4_raddr2", RADDR, 4'h0);
    deselect();
    check_strobes("t4", 0, none);

    // 5: deselect mid-byte discards the partial byte.
    select();
    xfer(8'h02, 8, rx);
    xfer(8'hE7, 5, rx);
    deselect();
    check("t5_miso", MISO,    1'b1);
    check("t5_oe",   MISO_OE, 1'b0);
    check_strobes("t5", 0, none);

    // SCLK activity while deselected must not disturb the next frame.
    xfer(8'hFF, 4, rx);
    select();
    xfer(8'h05, 8, rx);
    check("t5_id", rx, 8'hA5);
    xfer(8'h3C, 8, rx);
    deselect();
    check_strobes("t5_next", 1, '{12'h53C, 12'h000, 12'h000});

    // Command-only frame produces no strobe.
    select();
    xfer(8'h07, 8, rx);
    deselect();
    check_strobes("cmd_only", 0, none);

    // Reset mid-transaction returns outputs to reset values and waits for nCS high.
    select();
    xfer(8'h04, 8, rx);
    xfer(8'hFF, 3, rx);
    nRES = 1'b0;
    wait_clk(3);
    check("mr_waddr", WADDR,   4'h0);
    check("mr_wdata", WDATA,   8'h00);
    check("mr_raddr", RADDR,   4'h0);
    check("mr_miso",  MISO,    1'b1);
    check("mr_oe",    MISO_OE, 1'b0);
`ifdef SPI_RESPONDER_IRQ_EN
    check("mr_nirq",  nIRQ,    1'b1);
`endif
    nRES = 1'b1;
    wait_clk(5);
    xfer(8'h12, 8, rx);
    xfer(8'h34, 8, rx);
    check("mr_oe_held", MISO_OE, 1'b0);
    nCS = 1'b1;
    wait_clk(8);
    check_strobes("mr", 0, none);
    select();
    xfer(8'h09, 8, rx);
    check("mr_id", rx, 8'hA5);
    xfer(8'h5A, 8, rx);
    deselect();
    check_strobes("mr_next", 1, '{12'h95A, 12'h000, 12'h000});

`ifdef SPI_RESPONDER_IRQ_EN
    // 6: interrupt from completed write frames, acknowledged by IRQ_ACK.
    check("irq_pending", nIRQ, 1'b0);
    IRQ_ACK = 1'b1;
    wait_clk(1);
    IRQ_ACK = 1'b0;
    check("irq_ack0", nIRQ, 1'b1);
    select();
    xfer(8'h81, 8, rx);
    xfer(8'h00, 8, rx);
    deselect();
    check("irq_read", nIRQ, 1'b1);
    select();
    xfer(8'h01, 8, rx);
    deselect();
    check("irq_cmd_only", nIRQ, 1'b1);
    select();
    xfer(8'h01, 8, rx);
    xfer(8'h77, 8, rx);
    deselect();
    check("irq_set", nIRQ, 1'b0);
    check_strobes("irq_wr", 1, '{12'h177, 12'h000, 12'h000});
    wait_clk(10);
    check("irq_hold", nIRQ, 1'b0);
    IRQ_ACK = 1'b1;
    wait_clk(1);
    IRQ_ACK = 1'b0;
    check("irq_ack1", nIRQ, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
